viterbi_core_param: RTL

- Parametrised successor to the fixed 16-state, 32-step Viterbi decoder.
- Decodes the minimum-cost hidden-state path for an observation sequence stored in an internal RAM.
- New over the previous generation: runtime sequence length, runtime transition weight, a saturating metric, error reporting and final-metric readout.
- Sits behind the host's load/start/readback interface in the sequence-decoding subsystem.

---
 rtl/viterbi_core_param_if.sv | 33 +++
 rtl/viterbi_core_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/viterbi_core_param_if.sv
// Host-side bundle for viterbi_core_param: observation load, run control and path readback.
interface viterbi_core_param_if #(
    parameter int unsigned N_STATES = 16,
    parameter int unsigned T_MAX    = 32,
    parameter int unsigned OBS_W    = 8,
    parameter int unsigned METRIC_W = 12
);
    localparam int unsigned AW = $clog2(T_MAX);
    localparam int unsigned SW = $clog2(N_STATES);

    logic                obs_we;
    logic [AW-1:0]       obs_addr;
    logic [OBS_W-1:0]    obs_din;
    logic [AW:0]         seq_len;
    logic [3:0]          trans_w;
    logic                start;
    logic                busy;
    logic                done;
    logic                err;
    logic [METRIC_W-1:0] final_metric;
    logic [AW-1:0]       path_addr;
    logic [SW-1:0]       path_dout;

    modport master (
        output obs_we, obs_addr, obs_din, seq_len, trans_w, start, path_addr,
        input  busy, done, err, final_metric, path_dout
    );

    modport slave (
        input  obs_we, obs_addr, obs_din, seq_len, trans_w, start, path_addr,
        output busy, done, err, final_metric, path_dout
    );
endinterface

// File: rtl/viterbi_core_param.sv
// Parametrised minimum-cost Viterbi decoder: one (i,j) add-compare-select per cycle,
// ping-pong metric banks, backpointer RAM and traceback into a readable path RAM.
module viterbi_core_param #(
    parameter int unsigned N_STATES = 16,
    parameter int unsigned T_MAX    = 32,
    parameter int unsigned OBS_W    = 8,
    parameter int unsigned METRIC_W = 12
) (
    input logic             clk,
    input logic             rst,
    viterbi_core_param_if.slave bus
);
    localparam int unsigned AW = $clog2(T_MAX);
    localparam int unsigned SW = $clog2(N_STATES);
    localparam int unsigned LW = AW + 1;
    // Headroom for metric + 15 * (N_STATES-1) before clamping.
    localparam int unsigned WW = METRIC_W + 10;
    localparam logic [METRIC_W-1:0] MAX_M = '1;

    typedef enum logic [2:0] {StIdle, StInit, StFwd, StFinal, StTrace, StDone} state_e;

    state_e state_q, state_d;

    logic [OBS_W-1:0]    obs_mem    [T_MAX];
    logic [METRIC_W-1:0] metric_mem [2][N_STATES];
    logic [SW-1:0]       bp_mem     [T_MAX*N_STATES];
    logic [SW-1:0]       path_mem   [T_MAX];

    logic [AW-1:0]       t_q;
    logic [SW-1:0]       i_q, j_q, arg_q, s_q;
    logic [LW-1:0]       len_q;
    logic [3:0]          tw_q;
    logic                bank_q, err_q;
    logic [METRIC_W-1:0] best_q, final_q;
    logic [SW-1:0]       path_dout_q;

    logic busy, done, err, start_ok, i_last, j_last, take;
    logic [OBS_W-1:0]    cur_obs;
    logic [SW-1:0]       dist_ij, arg_n;
    logic [METRIC_W-1:0] prev_m, cand, cmp_val, best_n, new_m, init_m;

    function automatic logic [METRIC_W-1:0] sat_add(input logic [WW-1:0] a,
                                                    input logic [WW-1:0] b);
        logic [WW-1:0] s;
        s = a + b;
        return (s > WW'(MAX_M)) ? MAX_M : s[METRIC_W-1:0];
    endfunction

    // Circular distance between state j and the observation folded onto the state ring.
    function automatic logic [SW:0] emit(input logic [SW-1:0] j, input logic [OBS_W-1:0] obs);
        logic [SW-1:0] o;
        logic [SW:0]   d, r;
        o = obs[SW-1:0];
        d = (j >= o) ? {1'b0, j - o} : {1'b0, o - j};
        r = (SW+1)'(N_STATES) - d;
        return (r < d) ? r : d;
    endfunction

    assign start_ok = (bus.seq_len != '0) && (bus.seq_len <= LW'(T_MAX));
    assign i_last   = (i_q == SW'(N_STATES - 1));
    assign j_last   = (j_q == SW'(N_STATES - 1));
    assign cur_obs  = obs_mem[t_q];
    assign dist_ij  = (i_q >= j_q) ? (i_q - j_q) : (j_q - i_q);
    assign prev_m   = metric_mem[bank_q][i_q];
    assign cand     = sat_add(WW'(prev_m), WW'(tw_q) * WW'(dist_ij));
    // FINAL reuses the compare-select on raw metrics; lowest index wins ties.
    assign cmp_val  = (state_q == StFwd) ? cand : prev_m;
    assign take     = (i_q == '0) || (cmp_val < best_q);
    assign best_n   = take ? cmp_val : best_q;
    assign arg_n    = take ? i_q : arg_q;
    assign new_m    = sat_add(WW'(best_n), WW'(emit(j_q, cur_obs)));
    assign init_m   = sat_add('0, WW'(emit(j_q, cur_obs)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = start_ok ? StInit : StDone;
            StInit:  if (j_last) state_d = (len_q == LW'(1)) ? StFinal : StFwd;
            StFwd:   if (i_last && j_last && ({1'b0, t_q} == len_q - LW'(1))) state_d = StFinal;
            StFinal: if (i_last) state_d = StTrace;
            StTrace: if (t_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StInit, StFwd, StFinal, StTrace: busy = 1'b1;
            StDone:                          done = 1'b1;
            default: ;
        endcase
        err = done & err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            arg_q       <= '0;
            s_q         <= '0;
            len_q       <= '0;
            tw_q        <= '0;
            bank_q      <= 1'b0;
            err_q       <= 1'b0;
            best_q      <= '0;
            final_q     <= '0;
            path_dout_q <= '0;
        end else begin
            path_dout_q <= path_mem[bus.path_addr];
            unique case (state_q)
                StIdle: if (bus.start) begin
                    len_q  <= bus.seq_len;
                    tw_q   <= bus.trans_w;
                    err_q  <= !start_ok;
                    t_q    <= '0;
                    i_q    <= '0;
                    j_q    <= '0;
                    bank_q <= 1'b0;
                end
                StInit: begin
                    j_q <= j_q + 1'b1;
                    if (j_last) t_q <= AW'(1);
                end
                StFwd: begin
                    best_q <= best_n;
                    arg_q  <= arg_n;
                    i_q    <= i_q + 1'b1;
                    if (i_last) begin
                        j_q <= j_q + 1'b1;
                        if (j_last) begin
                            bank_q <= ~bank_q;
                            t_q    <= t_q + 1'b1;
                        end
                    end
                end
                StFinal: begin
                    best_q <= best_n;
                    arg_q  <= arg_n;
                    i_q    <= i_q + 1'b1;
                    if (i_last) begin
                        final_q <= best_n;
                        s_q     <= arg_n;
                        t_q     <= AW'(len_q - LW'(1));
                    end
                end
                StTrace: begin
                    s_q <= bp_mem[{t_q, s_q}];
                    t_q <= t_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // RAMs carry no reset; their write enables derive from the reset FSM state.
    always_ff @(posedge clk) begin
        if (bus.obs_we && !busy) obs_mem[bus.obs_addr] <= bus.obs_din;
        if (state_q == StInit) metric_mem[0][j_q] <= init_m;
        if (state_q == StFwd && i_last) begin
            metric_mem[~bank_q][j_q] <= new_m;
            bp_mem[{t_q, j_q}]       <= arg_n;
        end
        if (state_q == StTrace) path_mem[t_q] <= s_q;
    end

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.err          = err;
    assign bus.final_metric = final_q;
    assign bus.path_dout    = path_dout_q;
endmodule
